mem_stage_ext: RTL

Parametrised memory stage for the 5-stage pipeline, between EX and WB, using the same valid/allowin handshake as the other stages.
- Generalises the fixed single-cycle memory stage to a request/response data SRAM with variable data_ok latency.
- Adds byte/half/word(/double) load extraction with sign/zero extension, a one-entry response buffer, flush with cancellation of in-flight responses, and a forwarding bus to ID.

---
 rtl/mem_stage_ext_if.sv | 37 +++
 rtl/mem_stage_ext.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mem_stage_ext_if.sv
// Handshake and data bundle between EX, MEM, WB, the data SRAM and ID.
// The master side drives the stage; the slave side is the stage itself.
interface mem_stage_ext_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int RA_W   = 5
);
    localparam int OFS_W = $clog2(DATA_W / 8);
    localparam int ES_W  = 3 + OFS_W + 4 + RA_W + DATA_W + PC_W;
    localparam int WS_W  = 1 + RA_W + DATA_W + PC_W;
    localparam int FW_W  = 2 + RA_W + DATA_W;

    logic              ws_allowin;
    logic              ms_allowin;
    logic              es_to_ms_valid;
    logic [ES_W-1:0]   es_to_ms_bus;
    logic              ms_to_ws_valid;
    logic [WS_W-1:0]   ms_to_ws_bus;
    logic              ms_flush;
    logic              data_sram_data_ok;
    logic [DATA_W-1:0] data_sram_rdata;
    logic [FW_W-1:0]   ms_fwd_bus;

    modport master (
        output ws_allowin, es_to_ms_valid, es_to_ms_bus,
        output ms_flush, data_sram_data_ok, data_sram_rdata,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus,
        input  ms_fwd_bus
    );

    modport slave (
        input  ws_allowin, es_to_ms_valid, es_to_ms_bus,
        input  ms_flush, data_sram_data_ok, data_sram_rdata,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus,
        output ms_fwd_bus
    );
endinterface

// File: rtl/mem_stage_ext.sv
// Memory stage: waits for data_sram responses, extracts loads,
// buffers one early response and cancels responses of flushed loads.
module mem_stage_ext #(
    parameter int DATA_W   = 32,
    parameter int PC_W     = 32,
    parameter int RA_W     = 5,
    parameter int CANCEL_W = 2
) (
    input  logic           clk,
    input  logic           reset,
    mem_stage_ext_if.slave ms_if
);
    localparam int OFS_W = $clog2(DATA_W / 8);
    localparam int ES_W  = 3 + OFS_W + 4 + RA_W + DATA_W + PC_W;
    localparam int SH_W  = OFS_W + 3;
    localparam logic [CANCEL_W-1:0] CNT_MAX = '1;
    localparam logic [SH_W-1:0]     HALF_M  = ~SH_W'(15);
    localparam logic [SH_W-1:0]     WORD_M  = ~SH_W'(31);

    logic                ms_valid_q, ms_valid_d;
    logic [ES_W-1:0]     bus_q, bus_d;
    logic                buf_valid_q, buf_valid_d;
    logic [DATA_W-1:0]   buf_data_q, buf_data_d;
    logic [CANCEL_W-1:0] cancel_q, cancel_d;

    logic [2:0]        ld_op;
    logic [OFS_W-1:0]  addr_lo;
    logic              req_issued;
    logic              store_op;
    logic              load_op;
    logic              gr_we;
    logic [RA_W-1:0]   dest;
    logic [DATA_W-1:0] exe_result;
    logic [PC_W-1:0]   pc;

    assign {ld_op, addr_lo, req_issued, store_op, load_op,
            gr_we, dest, exe_result, pc} = bus_q;

    logic need_resp;
    logic cancel_zero;
    logic data_ok_live;
    logic ms_ready_go;
    logic ms_leave;
    logic allowin;
    logic cancel_inc;
    logic cancel_dec;

    assign need_resp    = ms_valid_q & (load_op | store_op) & req_issued;
    assign cancel_zero  = (cancel_q == '0);
    assign data_ok_live = ms_if.data_sram_data_ok & cancel_zero;
    assign ms_ready_go  = ~need_resp | buf_valid_q | data_ok_live;
    assign ms_leave     = ms_valid_q & ms_ready_go & ms_if.ws_allowin;
    assign allowin      = (~ms_valid_q | ms_leave) & (cancel_q != CNT_MAX);

    // A response still owed to a flushed load must be swallowed later.
    assign cancel_inc = ms_if.ms_flush & need_resp & ~buf_valid_q
                      & ~data_ok_live & (cancel_q != CNT_MAX);
    assign cancel_dec = ms_if.data_sram_data_ok & ~cancel_zero;

    logic [DATA_W-1:0] word;
    logic [SH_W-1:0]   byte_sh;
    logic [SH_W-1:0]   half_sh;
    logic [SH_W-1:0]   word_sh;
    logic [7:0]        b8;
    logic [15:0]       h16;
    logic [31:0]       w32;
    logic [63:0]       ext64;
    logic [DATA_W-1:0] extracted;
    logic [DATA_W-1:0] final_result;

    assign word    = buf_valid_q ? buf_data_q : ms_if.data_sram_rdata;
    assign byte_sh = {addr_lo, 3'b000};
    assign half_sh = byte_sh & HALF_M;
    assign word_sh = byte_sh & WORD_M;
    assign b8      = 8'(word >> byte_sh);
    assign h16     = 16'(word >> half_sh);
    assign w32     = 32'(word >> word_sh);

    // Select and extend the loaded field; encodings 4 and 7 are LW.
    always_comb begin
        ext64 = {{32{w32[31]}}, w32};
        case (ld_op)
            3'd0: ext64 = {{56{b8[7]}}, b8};
            3'd1: ext64 = {56'b0, b8};
            3'd2: ext64 = {{48{h16[15]}}, h16};
            3'd3: ext64 = {48'b0, h16};
            3'd5: ext64 = {32'b0, w32};
            3'd6: ext64 = (DATA_W == 64) ? 64'(word)
                                         : {{32{w32[31]}}, w32};
            default: ext64 = {{32{w32[31]}}, w32};
        endcase
    end

    assign extracted    = DATA_W'(ext64);
    assign final_result = (ms_valid_q & load_op) ? extracted : exe_result;

    // Next-state for the resident instruction, response buffer and
    // cancelled-response counter.
    always_comb begin
        ms_valid_d  = ms_valid_q;
        bus_d       = bus_q;
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
        cancel_d    = cancel_q;

        if (ms_if.ms_flush) begin
            ms_valid_d = 1'b0;
        end else if (allowin) begin
            ms_valid_d = ms_if.es_to_ms_valid;
        end else if (ms_leave) begin
            ms_valid_d = 1'b0;
        end

        if (ms_if.es_to_ms_valid & allowin) begin
            bus_d = ms_if.es_to_ms_bus;
        end

        if (ms_if.ms_flush | ms_leave) begin
            buf_valid_d = 1'b0;
        end else if (need_resp & ~buf_valid_q & data_ok_live) begin
            buf_valid_d = 1'b1;
            buf_data_d  = ms_if.data_sram_rdata;
        end

        if (cancel_inc & ~cancel_dec) begin
            cancel_d = cancel_q + CANCEL_W'(1);
        end else if (cancel_dec & ~cancel_inc) begin
            cancel_d = cancel_q - CANCEL_W'(1);
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_q  <= 1'b0;
            buf_valid_q <= 1'b0;
            cancel_q    <= '0;
        end else begin
            ms_valid_q  <= ms_valid_d;
            buf_valid_q <= buf_valid_d;
            cancel_q    <= cancel_d;
        end
    end

    // Payload registers need no reset; valid bits qualify them.
    always_ff @(posedge clk) begin
        bus_q      <= bus_d;
        buf_data_q <= buf_data_d;
    end

    assign ms_if.ms_allowin     = allowin;
    assign ms_if.ms_to_ws_valid = ms_valid_q & ms_ready_go & ~ms_if.ms_flush;
    assign ms_if.ms_to_ws_bus   = {gr_we, dest, final_result, pc};
    assign ms_if.ms_fwd_bus     = {ms_valid_q & gr_we,
                                   ms_valid_q & load_op & ~ms_ready_go,
                                   dest, final_result};
endmodule
